approx_error_monitor: RTL and testbench
=======================================

Name: approx_error_monitor

Overview:
- Sits directly downstream of the 4-bit approximate multiplier (te). Samples each operand pair (in1, in2) with the multiplier's 8-bit out.
- Computes the exact product internally and derives the error distance ED = |exact - approx|.
- Accumulates error statistics over a fixed window of N samples and presents them with a valid/ack handshake.
- Used on-chip and in simulation to characterise approximate-multiplier accuracy: mean ED, max ED, error rate.

Parameters:
W, 4, operand width; product width is 2*W
WIN_LOG2, 8, window length N = 2**WIN_LOG2 samples
SUM_W, 2*W+WIN_LOG2, width of the ED sum accumulator (cannot overflow)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; clears statistics and begins a window
in_valid  input  1  in1/in2/approx_out hold a valid sample
in_ready  output  1  block accepts a sample this cycle
in1  input  W  multiplicand as fed to the multiplier
in2  input  W  multiplier operand as fed to the multiplier
approx_out  input  2*W  approximate product from the multiplier
res_valid  output  1  statistics are final and stable
res_ack  input  1  consumer has taken the results
ed_sum  output  SUM_W  sum of ED over the window
ed_max  output  2*W  largest ED in the window
err_cnt  output  WIN_LOG2+1  number of samples with ED != 0

Behaviour:
- Reset: every output and internal register is 0. FSM goes to IDLE. Reset mid-window discards all partial state.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start. Entering RUN clears ed_sum, ed_max, err_cnt and the sample counter.
- RUN: in_ready = 1. A sample is accepted when in_valid && in_ready.
  - After the N-th acceptance, in_ready drops the next cycle and the FSM moves to DRAIN.
  - start while in RUN is ignored.
- DRAIN: lasts exactly 2 cycles so the pipeline empties, then the FSM moves to DONE.
- DONE: res_valid = 1. Outputs hold until the handshake below.
  - res_ack -> IDLE; res_valid drops the next cycle.
  - start -> RUN, with fresh clears.
  - start and res_ack in the same cycle: start wins.
- in_ready = 0 in IDLE, DRAIN and DONE. in_valid is ignored in those states.
- Pipeline, 2 stages:
  - S1 registers approx_out and exact = in1*in2 (unsigned, 2*W bits).
  - S2 registers ED = |exact - approx_out|, using an unsigned compare and then the subtract; approx above exact is handled.
  - Statistics update on the cycle after S2. Total sample-to-statistics latency is 3 cycles.
- Statistics update rules:
  - ed_sum adds ED, zero-extended to SUM_W.
  - ed_max is replaced only when ED > ed_max; ties keep the old value.
  - err_cnt increments when ED != 0.
  - The sample counter is WIN_LOG2+1 bits and reaches exactly N; it never wraps inside a window.
- Outputs in RUN/DRAIN show live partial values. They are valid only while res_valid = 1.

Optional Feature:
- Macro: APPROX_ERR_SQ_EN.
- Defined:
  - Extra output port sq_sum, width 4*W+WIN_LOG2, accumulating ED*ED for MSE.
  - The squaring is registered in an extra S3 stage, so total latency becomes 4 cycles and DRAIN lasts 3 cycles.
  - Cleared and held exactly like ed_sum.
- Undefined: no sq_sum port, no S3 stage, latency and DRAIN as described in Behaviour.

Decomposition:
- Package approx_mul_pkg holds:
  - W_DEF, WIN_LOG2_DEF
  - the FSM state enum (IDLE/RUN/DRAIN/DONE)
  - the pipeline latency constant (2, or 3 when APPROX_ERR_SQ_EN is defined), which sets the DRAIN length
- One sub-module, err_dist_stage: the S1/S2 pipeline (exact product plus absolute difference), with a valid bit passed alongside the data.
- The top level holds the FSM, the counters and the accumulators.

Test Plan:
- Bench runs with WIN_LOG2 = 2 (N = 4).
- Reset held for 3 cycles, then released -> all outputs 0, in_ready = 0, res_valid = 0.
- Exact window: start, then 4 samples of in1=10, in2=15, approx_out=150 -> res_valid 3 cycles after the last acceptance; ed_sum=0, ed_max=0, err_cnt=0.
- Mixed error: start, then approx_out = 150, 146, 154, 150 for 10x15 -> ED 0, 4, 4, 0.
  - Expect ed_sum=8, ed_max=4 (the tie keeps the first 4), err_cnt=2.
  - Covers approx > exact.
- Backpressure and ignore rules:
  - in_valid held high for 6 cycles -> only 4 samples accepted; in_ready drops after the 4th.
  - start pulsed during RUN -> no effect.
- Handshake:
  - In DONE, assert res_ack -> res_valid low the next cycle, FSM in IDLE, outputs unchanged.
  - In DONE, assert start together with res_ack -> a new window begins and statistics clear to 0.
- Reset mid-window: rst after 2 samples -> all statistics 0, in_ready = 0.
  - A following start plus 4 exact samples -> ed_sum=0.

Source files
------------

// File: rtl/approx_mul_pkg.sv
// approx_mul_pkg
//   Shared constants and types for the approximate-multiplier error monitor.
//   - W_DEF / WIN_LOG2_DEF : default operand width and window size exponent
//   - PIPE_LAT             : cycles from sample acceptance to the statistics
//                            input; also the number of DRAIN cycles
//   - state_e              : monitor FSM states
//   Optional feature macro: APPROX_ERR_SQ_EN (adds the squaring stage,
//   which lengthens the pipeline by one cycle).
package approx_mul_pkg;

  localparam int W_DEF        = 4;
  localparam int WIN_LOG2_DEF = 8;

`ifdef APPROX_ERR_SQ_EN
  localparam int PIPE_LAT = 3;
`else
  localparam int PIPE_LAT = 2;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/approx_error_monitor_err_dist.sv
// err_dist_stage
//   Two-stage pipeline computing the error distance between the exact
//   product of the operands and the approximate multiplier output.
//   S1 registers the exact product and the approximate product; S2 registers
//   ED = |exact - approx|. A valid bit travels alongside the data.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     valid_i     : sample accepted this cycle
//     in1_i/in2_i : operands as fed to the multiplier (W bits)
//     approx_i    : approximate product (2*W bits)
//     ed_o        : error distance, two cycles after acceptance
//     ed_valid_o  : ed_o carries a real sample
module err_dist_stage
  import approx_mul_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid_i,
  input  logic [W-1:0]   in1_i,
  input  logic [W-1:0]   in2_i,
  input  logic [2*W-1:0] approx_i,
  output logic [2*W-1:0] ed_o,
  output logic           ed_valid_o
);

  localparam int PW = 2 * W;

  logic [PW-1:0] exact_d;
  logic [PW-1:0] exact_q;
  logic [PW-1:0] approx_q;
  logic [PW-1:0] ed_d;
  logic [PW-1:0] ed_q;
  logic          v1_q;
  logic          v2_q;

  always_comb begin
    exact_d = PW'(in1_i) * PW'(in2_i);
  end

  // Compare first so the subtraction never underflows; approx may exceed
  // exact for some approximate multiplier designs.
  always_comb begin
    if (exact_q >= approx_q) begin
      ed_d = exact_q - approx_q;
    end else begin
      ed_d = approx_q - exact_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      exact_q  <= '0;
      approx_q <= '0;
      v2_q     <= 1'b0;
      ed_q     <= '0;
    end else begin
      v1_q     <= valid_i;
      exact_q  <= exact_d;
      approx_q <= approx_i;
      v2_q     <= v1_q;
      ed_q     <= ed_d;
    end
  end

  assign ed_o       = ed_q;
  assign ed_valid_o = v2_q;

endmodule

// File: rtl/approx_error_monitor.sv
// approx_error_monitor
//   Characterises an approximate multiplier: for each accepted sample it
//   computes ED = |in1*in2 - approx_out| and accumulates, over a window of
//   N = 2**WIN_LOG2 samples, the ED sum, the maximum ED and the count of
//   samples with a non-zero ED.
//   Ports:
//     clk, rst              : clock, synchronous active-high reset
//     start                 : one-cycle pulse, clears stats and opens a window
//     in_valid / in_ready   : sample handshake
//     in1, in2, approx_out  : operands and approximate product
//     res_valid / res_ack   : result handshake
//     ed_sum, ed_max, err_cnt : statistics (live in RUN/DRAIN, final in DONE)
//     state_o               : current FSM state (debug)
//     sq_sum                : sum of ED*ED, only with APPROX_ERR_SQ_EN
//   Optional feature macro: APPROX_ERR_SQ_EN.
//
//   Handshakes: a sample transfers on a rising edge where in_valid and
//   in_ready are both high; in_ready is high exactly in RUN and does not
//   depend on in_valid. res_valid is high exactly in DONE; the results are
//   consumed on an edge where res_valid and res_ack are both high, unless
//   start is also high, in which case a new window begins instead.
module approx_error_monitor
  import approx_mul_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int WIN_LOG2 = WIN_LOG2_DEF,
  parameter int SUM_W    = 2 * W + WIN_LOG2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in1,
  input  logic [W-1:0]        in2,
  input  logic [2*W-1:0]      approx_out,
  output logic                res_valid,
  input  logic                res_ack,
  output logic [SUM_W-1:0]    ed_sum,
  output logic [2*W-1:0]      ed_max,
  output logic [WIN_LOG2:0]   err_cnt,
  output state_e              state_o
`ifdef APPROX_ERR_SQ_EN
  ,
  output logic [4*W+WIN_LOG2-1:0] sq_sum
`endif
);

  localparam int PW    = 2 * W;
  localparam int CNT_W = WIN_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_SMP   = CNT_W'((1 << WIN_LOG2) - 1);
  localparam logic [1:0]       LAST_DRAIN = 2'(PIPE_LAT - 1);

  state_e             state_q;
  state_e             state_d;
  logic               clear;
  logic               accept;
  logic [CNT_W-1:0]   smp_cnt_q;
  logic [1:0]         drain_cnt_q;
  logic [SUM_W-1:0]   ed_sum_q;
  logic [PW-1:0]      ed_max_q;
  logic [CNT_W-1:0]   err_cnt_q;

  logic [PW-1:0]      s2_ed;
  logic               s2_valid;
  logic [PW-1:0]      st_ed;
  logic               st_valid;

  // ---------------- FSM ----------------
  always_comb begin
    state_d   = state_q;
    clear     = 1'b0;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          clear   = 1'b1;
        end
      end
      ST_RUN: begin
        in_ready = 1'b1;
        if (in_valid && (smp_cnt_q == LAST_SMP)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == LAST_DRAIN) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (start) begin
          state_d = ST_RUN;
          clear   = 1'b1;
        end else if (res_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign accept  = in_valid && in_ready;
  assign state_o = state_q;

  // ---------------- counters ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_cnt_q   <= '0;
      drain_cnt_q <= '0;
    end else begin
      if (clear) begin
        smp_cnt_q <= '0;
      end else if (accept) begin
        smp_cnt_q <= smp_cnt_q + 1'b1;
      end
      // Restarts on every entry to DRAIN because it is held at zero elsewhere.
      if (state_q == ST_DRAIN) begin
        drain_cnt_q <= drain_cnt_q + 1'b1;
      end else begin
        drain_cnt_q <= '0;
      end
    end
  end

  // ---------------- pipeline ----------------
  err_dist_stage #(.W(W)) u_err_dist (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (accept),
    .in1_i      (in1),
    .in2_i      (in2),
    .approx_i   (approx_out),
    .ed_o       (s2_ed),
    .ed_valid_o (s2_valid)
  );

`ifdef APPROX_ERR_SQ_EN
  localparam int SQ_PW = 2 * PW;
  localparam int SQ_W  = 4 * W + WIN_LOG2;

  logic [SQ_PW-1:0] sq3_q;
  logic [PW-1:0]    ed3_q;
  logic             v3_q;
  logic [SQ_W-1:0]  sq_sum_q;

  // S3: square the ED; the plain ED is delayed alongside so every
  // statistic updates on the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sq3_q <= '0;
      ed3_q <= '0;
      v3_q  <= 1'b0;
    end else begin
      sq3_q <= SQ_PW'(s2_ed) * SQ_PW'(s2_ed);
      ed3_q <= s2_ed;
      v3_q  <= s2_valid;
    end
  end

  assign st_ed    = ed3_q;
  assign st_valid = v3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sq_sum_q <= '0;
    end else if (clear) begin
      sq_sum_q <= '0;
    end else if (st_valid) begin
      sq_sum_q <= sq_sum_q + SQ_W'(sq3_q);
    end
  end

  assign sq_sum = sq_sum_q;
`else
  assign st_ed    = s2_ed;
  assign st_valid = s2_valid;
`endif

  // ---------------- statistics ----------------
  // The pipeline is empty whenever clear fires (IDLE or DONE), so giving
  // clear priority never drops a sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      ed_sum_q  <= '0;
      ed_max_q  <= '0;
      err_cnt_q <= '0;
    end else if (clear) begin
      ed_sum_q  <= '0;
      ed_max_q  <= '0;
      err_cnt_q <= '0;
    end else if (st_valid) begin
      ed_sum_q <= ed_sum_q + SUM_W'(st_ed);
      if (st_ed > ed_max_q) begin
        ed_max_q <= st_ed;
      end
      if (st_ed != '0) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign ed_sum  = ed_sum_q;
  assign ed_max  = ed_max_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_approx_error_monitor.sv
// tb_approx_error_monitor
//   Directed bench for approx_error_monitor with N = 4 samples per window.
//   Inputs change 1 time unit after the rising edge; outputs are sampled at
//   the same point, well clear of the next edge.
module tb_approx_error_monitor;
  import approx_mul_pkg::*;

  localparam int W        = 4;
  localparam int WIN_LOG2 = 2;
  localparam int SUM_W    = 2 * W + WIN_LOG2;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       in1;
  logic [W-1:0]       in2;
  logic [2*W-1:0]     approx_out;
  logic               res_valid;
  logic               res_ack;
  logic [SUM_W-1:0]   ed_sum;
  logic [2*W-1:0]     ed_max;
  logic [WIN_LOG2:0]  err_cnt;
  state_e             state_o;

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  approx_error_monitor #(
    .W        (W),
    .WIN_LOG2 (WIN_LOG2),
    .SUM_W    (SUM_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in1        (in1),
    .in2        (in2),
    .approx_out (approx_out),
    .res_valid  (res_valid),
    .res_ack    (res_ack),
    .ed_sum     (ed_sum),
    .ed_max     (ed_max),
    .err_cnt    (err_cnt),
    .state_o    (state_o)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int a, input int b, input int p);
    in_valid   = 1'b1;
    in1        = W'(a);
    in2        = W'(b);
    approx_out = (2*W)'(p);
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expd);
    end
  endtask

  task automatic check_stats(input string tag, input int s, input int m, input int c);
    check({tag, "_ed_sum"},  32'(ed_sum),  32'(s));
    check({tag, "_ed_max"},  32'(ed_max),  32'(m));
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'(c));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int mix_p[4];
    int bp_a[6];
    int bp_b[6];
    int bp_p[6];
    mix_p = '{150, 146, 154, 150};
    // EDs: 1, 0, 25, 1 for the first four; the last two would add 225 each.
    bp_a  = '{2, 4, 15, 1, 15, 15};
    bp_b  = '{3, 4, 15, 1, 15, 15};
    bp_p  = '{7, 16, 200, 0, 0, 0};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; res_ack = 1'b0;
    in1 = '0; in2 = '0; approx_out = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_state",     32'(state_o),   32'(ST_IDLE));
    check_stats("rst", 0, 0, 0);

    // Exact window: ED 0 on every sample
    start = 1'b1; tick(); start = 1'b0;
    check("exact_run_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(10, 15, 150);
      tick();
    end
    in_valid = 1'b0;
    check("exact_ready_drop", 32'(in_ready),  32'd0);
    check("exact_state_drain", 32'(state_o),  32'(ST_DRAIN));
    check("exact_rv_lat1",    32'(res_valid), 32'd0);
    tick();
    check("exact_rv_lat2",    32'(res_valid), 32'd0);
    tick();
    check("exact_rv_lat3",    32'(res_valid), 32'd1);
    check_stats("exact", 0, 0, 0);

    // Ack returns to IDLE
    res_ack = 1'b1; tick(); res_ack = 1'b0;
    check("exact_ack_rv",    32'(res_valid), 32'd0);
    check("exact_ack_state", 32'(state_o),   32'(ST_IDLE));

    // Mixed errors: ED 0, 4, 4, 0; approx above exact on the third sample
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(10, 15, mix_p[i]);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("mix_rv", 32'(res_valid), 32'd1);
    check_stats("mix", 8, 4, 2);

    res_ack = 1'b1; tick(); res_ack = 1'b0;
    check("mix_ack_rv",    32'(res_valid), 32'd0);
    check("mix_ack_state", 32'(state_o),   32'(ST_IDLE));
    check_stats("mix_ack", 8, 4, 2);

    // in_valid in IDLE is ignored
    drive(15, 15, 0);
    repeat (2) tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("idle_ready", 32'(in_ready), 32'd0);
    check_stats("idle_ignore", 8, 4, 2);

    // Backpressure: in_valid held 6 cycles, start pulsed mid-window
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(bp_a[i], bp_b[i], bp_p[i]);
      start = (i == 1);
      tick();
      start = 1'b0;
      check($sformatf("bp_ready_%0d", i), 32'(in_ready), (i < 3) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    check("bp_rv",    32'(res_valid), 32'd1);
    check("bp_state", 32'(state_o),   32'(ST_DONE));
    check_stats("bp", 27, 25, 3);

    // start together with res_ack in DONE: start wins
    start = 1'b1; res_ack = 1'b1; tick(); start = 1'b0; res_ack = 1'b0;
    check("both_state", 32'(state_o),   32'(ST_RUN));
    check("both_ready", 32'(in_ready),  32'd1);
    check("both_rv",    32'(res_valid), 32'd0);
    check_stats("both", 0, 0, 0);

    // Two large-error samples, then reset mid-window
    for (int i = 0; i < 2; i++) begin
      drive(10, 15, 0);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    check_stats("partial", 300, 150, 2);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_ready", 32'(in_ready), 32'd0);
    check("midrst_state", 32'(state_o),  32'(ST_IDLE));
    check_stats("midrst", 0, 0, 0);

    // Fresh window after reset
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(10, 15, 150);
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    check("post_rv", 32'(res_valid), 32'd1);
    check_stats("post", 0, 0, 0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
